// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side handshake and register-file write bus of the writeback stage.
interface wb_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
);
    logic               valid_i;
    logic               ready_o;
    logic               rd_we_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0]  alu_res_i;
    logic               is_load_i;
    logic [2:0]         ld_funct3_i;
    logic [DATA_W-1:0]  mem_rdata_i;
    logic               stall_i;
    logic               we_o;
    logic [RADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0]  wdata_o;
    logic               err_o;
    logic [CNT_W-1:0]   instret_o;

    modport slave (
        input  valid_i, rd_we_i, rd_addr_i, alu_res_i, is_load_i, ld_funct3_i, mem_rdata_i, stall_i,
        output ready_o, we_o, waddr_o, wdata_o, err_o, instret_o
    );

    modport master (
        output valid_i, rd_we_i, rd_addr_i, alu_res_i, is_load_i, ld_funct3_i, mem_rdata_i, stall_i,
        input  ready_o, we_o, waddr_o, wdata_o, err_o, instret_o
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with a 2-entry skid FIFO, load formatting and retired-instruction counter.
module wb_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input logic       clk_i,
    input logic       rst_i,
    wb_stage_if.slave bus
);
    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  res;
        logic               err;
    } entry_t;

    entry_t            fifo [2];
    entry_t            in_e;
    entry_t            head;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;
    logic              push, pop;
    logic [1:0]        off;
    logic [7:0]        b;
    logic [15:0]       h;
    logic              ld_err;
    logic [DATA_W-1:0] ld_val;

    assign bus.ready_o = rst_i && (count < 2'd2);
    assign push        = bus.valid_i && bus.ready_o;
    assign pop         = (count != 2'd0) && !bus.stall_i;
    assign head        = fifo[rd_ptr];

    // Load data is formatted at push time so mem_rdata_i need only be valid in that cycle.
    always_comb begin
        off    = bus.alu_res_i[1:0];
        b      = 8'(bus.mem_rdata_i >> {off, 3'b000});
        h      = off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        ld_err = 1'b0;
        ld_val = '0;
        case (bus.ld_funct3_i)
            3'b000: ld_val = {{(DATA_W-8){b[7]}}, b};
            3'b100: ld_val = {{(DATA_W-8){1'b0}}, b};
            3'b001: begin
                ld_err = off[0];
                ld_val = off[0] ? '0 : {{(DATA_W-16){h[15]}}, h};
            end
            3'b101: begin
                ld_err = off[0];
                ld_val = off[0] ? '0 : {{(DATA_W-16){1'b0}}, h};
            end
            3'b010: begin
                ld_err = off != 2'd0;
                ld_val = (off != 2'd0) ? '0 : bus.mem_rdata_i;
            end
            default: ld_err = 1'b1;
        endcase
        in_e = '{we:  bus.rd_we_i,
                 rd:  bus.rd_addr_i,
                 res: bus.is_load_i ? ld_val : bus.alu_res_i,
                 err: bus.is_load_i && ld_err};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            bus.we_o      <= 1'b0;
            bus.waddr_o   <= '0;
            bus.wdata_o   <= '0;
            bus.err_o     <= 1'b0;
            bus.instret_o <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= in_e;
                wr_ptr       <= ~wr_ptr;
            end
            bus.we_o  <= pop && head.we && (head.rd != '0) && !head.err;
            bus.err_o <= pop && head.err;
            if (pop) begin
                rd_ptr        <= ~rd_ptr;
                bus.waddr_o   <= head.rd;
                bus.wdata_o   <= head.res;
                bus.instret_o <= bus.instret_o + 1'b1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random stimulus against a queue-based reference model of the writeback stage.
module tb_wb_stage;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_chk = 0;
    int   n_ok  = 0;

    typedef struct {
        bit          we;
        int unsigned rd;
        int unsigned res;
        bit          err;
    } ent_t;

    ent_t           q[$];
    bit             m_we, m_err;
    int unsigned    m_waddr, m_wdata;
    longint unsigned m_cnt;

    wb_stage_if bus ();
    wb_stage dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference load formatting from the ISA rules, plain integer arithmetic.
    function automatic void fmt(input int unsigned alu, input int unsigned rdata, input bit ld,
                                input int unsigned f3, output int unsigned res, output bit err);
        int unsigned off = alu % 4;
        int unsigned by  = (rdata >> (8 * off)) % 256;
        int unsigned hw  = (rdata >> (16 * (off / 2))) % 65536;
        err = 0;
        res = alu;
        if (!ld) return;
        case (f3)
            0: res = (by >= 128) ? by + 32'hFFFF_FF00 : by;
            4: res = by;
            1: begin err = (off % 2) != 0; res = (hw >= 32768) ? hw + 32'hFFFF_0000 : hw; end
            5: begin err = (off % 2) != 0; res = hw; end
            2: begin err = off != 0; res = rdata; end
            default: err = 1;
        endcase
        if (err) res = 0;
    endfunction

    task automatic step(input bit v, input bit we, input int unsigned rd, input int unsigned alu,
                        input bit ld, input int unsigned f3, input int unsigned rdata, input bit st);
        bit   do_push, do_pop;
        ent_t e;
        bus.valid_i     = v;
        bus.rd_we_i     = we;
        bus.rd_addr_i   = 5'(rd);
        bus.alu_res_i   = alu;
        bus.is_load_i   = ld;
        bus.ld_funct3_i = 3'(f3);
        bus.mem_rdata_i = rdata;
        bus.stall_i     = st;
        #1 check("ready", 64'(bus.ready_o), 64'(rst_i && q.size() < 2));
        @(posedge clk_i);
        if (!rst_i) begin
            q.delete();
            {m_we, m_err, m_waddr, m_wdata, m_cnt} = '0;
        end else begin
            do_push = v && q.size() < 2;
            do_pop  = q.size() > 0 && !st;
            m_we    = 0;
            m_err   = 0;
            if (do_pop) begin
                e       = q.pop_front();
                m_we    = e.we && e.rd != 0 && !e.err;
                m_err   = e.err;
                m_waddr = e.rd;
                m_wdata = e.res;
                m_cnt++;
            end
            if (do_push) begin
                e.we = we;
                e.rd = rd % 32;
                fmt(alu, rdata, ld, f3, e.res, e.err);
                q.push_back(e);
            end
        end
        @(negedge clk_i);
        check("we", 64'(bus.we_o), 64'(m_we));
        check("err", 64'(bus.err_o), 64'(m_err));
        check("waddr", 64'(bus.waddr_o), 64'(m_waddr));
        check("wdata", 64'(bus.wdata_o), 64'(m_wdata));
        check("instret", bus.instret_o, m_cnt);
    endtask

    task automatic idle(input bit st = 0);
        step(0, 0, 0, 0, 0, 0, 0, st);
    endtask

    initial begin
        @(negedge clk_i);
        idle();
        idle();
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_instret", bus.instret_o, 64'd0);
        check("rst_wdata", 64'(bus.wdata_o), 64'd0);
        rst_i = 1'b1;

        step(1, 1, 5, 32'h1234_5678, 0, 0, 0, 0);
        idle();
        check("alu_we", 64'(bus.we_o), 64'd1);
        check("alu_waddr", 64'(bus.waddr_o), 64'd5);
        check("alu_wdata", 64'(bus.wdata_o), 64'h1234_5678);
        check("alu_instret", bus.instret_o, 64'd1);

        step(1, 1, 3, 32'h3, 1, 3'b000, 32'h80FF_0000, 0);
        idle();
        check("lb", 64'(bus.wdata_o), 64'hFFFF_FF80);
        step(1, 1, 3, 32'h3, 1, 3'b100, 32'h80FF_0000, 0);
        idle();
        check("lbu", 64'(bus.wdata_o), 64'h0000_0080);
        step(1, 1, 3, 32'h2, 1, 3'b001, 32'h80FF_0000, 0);
        idle();
        check("lh", 64'(bus.wdata_o), 64'hFFFF_80FF);

        step(1, 1, 7, 32'h1, 1, 3'b010, 32'hDEAD_BEEF, 0);
        idle();
        check("lw_mis_we", 64'(bus.we_o), 64'd0);
        check("lw_mis_err", 64'(bus.err_o), 64'd1);
        check("lw_mis_instret", bus.instret_o, 64'd5);
        idle();
        check("err_pulse", 64'(bus.err_o), 64'd0);
        step(1, 1, 9, 32'h0, 1, 3'b011, 32'h1, 0);
        idle();
        check("f3_011_err", 64'(bus.err_o), 64'd1);

        step(1, 1, 0, 32'hABCD, 0, 0, 0, 0);
        idle();
        check("rd0_we", 64'(bus.we_o), 64'd0);
        check("rd0_err", 64'(bus.err_o), 64'd0);
        check("rd0_instret", bus.instret_o, 64'd7);

        step(1, 1, 10, 32'hA, 0, 0, 0, 1);
        step(1, 1, 11, 32'hB, 0, 0, 0, 1);
        step(1, 1, 12, 32'hC, 0, 0, 0, 1);
        check("stall_full", 64'(bus.ready_o), 64'd0);
        step(1, 1, 12, 32'hC, 0, 0, 0, 0);
        check("drain1", 64'(bus.waddr_o), 64'd10);
        step(1, 1, 12, 32'hC, 0, 0, 0, 0);
        check("drain2", 64'(bus.waddr_o), 64'd11);
        idle();
        check("third", 64'(bus.wdata_o), 64'hC);

        step(1, 1, 20, 32'h20, 0, 0, 0, 1);
        step(1, 1, 21, 32'h21, 0, 0, 0, 1);
        rst_i = 1'b0;
        idle();
        check("mid_rst_ready", 64'(bus.ready_o), 64'd0);
        check("mid_rst_we", 64'(bus.we_o), 64'd0);
        check("mid_rst_instret", bus.instret_o, 64'd0);
        rst_i = 1'b1;
        repeat (3) idle();

        repeat (600) begin
            rst_i = ($urandom_range(99) >= 2);
            step($urandom_range(99) < 65, $urandom_range(1), $urandom_range(31), $urandom,
                 $urandom_range(1), $urandom_range(7), $urandom, $urandom_range(99) < 25);
        end
        rst_i = 1'b1;
        repeat (4) idle();

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
